addsub_seq_ctrl: RTL and testbench

ADDSUB_SEQ_CTRL -- requirements
Module: addsub_seq_ctrl

---
 rtl/addsub_seq_ctrl_if.sv | 32 +++
 rtl/addsub_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_addsub_seq_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_seq_ctrl_if
//  Purpose  : Request/response bundle for the nibble-serial add/subtract unit.
//  Revision : 1.0  initial release
// ============================================================================
interface addsub_seq_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         c_out;
    logic         ovf;

    modport master (
        output start, op, a, b,
        input  busy, done, result, c_out, ovf
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, c_out, ovf
    );
endinterface
`default_nettype wire

// File: rtl/addsub_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_seq_ctrl
//  Purpose  : W-bit add/subtract computed one 4-bit slice per cycle, LS first.
//  Revision : 1.0  initial release
// ============================================================================
module addsub_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    addsub_seq_ctrl_if.slave   bus
);
    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [IDXW-1:0] c_last_idx = IDXW'(NIBBLES - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;

    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_op;
    logic            r_carry;
    logic [IDXW-1:0] r_idx;
    logic [W-1:0]    r_result;
    logic            r_c_out;
    logic            r_ovf;

    logic [3:0]      w_a_nib;
    logic [3:0]      w_b_nib;
    logic [3:0]      w_bx;
    logic [4:0]      w_sum;
    logic            w_cy;
    logic            w_c_msb;
    logic            w_last;
    logic            w_accept;
    logic            w_busy;
    logic            w_done;

    assign w_accept = (r_state == c_st_idle) && bus.start;
    assign w_last   = (r_idx == c_last_idx);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: if (bus.start) w_next_state = c_st_run;
            c_st_run:  if (w_last)    w_next_state = c_st_done;
            c_st_done:                w_next_state = c_st_idle;
            default:                  w_next_state = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            c_st_run:  w_busy = 1'b1;
            c_st_done: w_done = 1'b1;
            default: begin
                w_busy = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shared 4-bit slice: operands selected by the current nibble index
    // ------------------------------------------------------------------
    always_comb begin
        w_a_nib = 4'd0;
        w_b_nib = 4'd0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_a_nib = r_a[i*4 +: 4];
                w_b_nib = r_b[i*4 +: 4];
            end
        end
    end

    assign w_bx  = w_b_nib ^ {4{r_op}};
    assign w_sum = {1'b0, w_a_nib} + {1'b0, w_bx} + {4'd0, r_carry};
    assign w_cy  = w_sum[4];
    // Carry into bit 3 recovered from the sum bit and its two operand bits.
    assign w_c_msb = w_sum[3] ^ w_a_nib[3] ^ w_bx[3];

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 1'b0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
            r_c_out  <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_op     <= bus.op;
            r_carry  <= bus.op;
            r_idx    <= '0;
            r_result <= '0;
        end else if (r_state == c_st_run) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (r_idx == IDXW'(i)) begin
                    r_result[i*4 +: 4] <= w_sum[3:0];
                end
            end
            r_carry <= w_cy;
            r_idx   <= r_idx + IDXW'(1);
            if (w_last) begin
                r_c_out <= w_cy;
                r_ovf   <= w_c_msb ^ w_cy;
            end
        end
    end

    assign bus.busy   = w_busy;
    assign bus.done   = w_done;
    assign bus.result = r_result;
    assign bus.c_out  = r_c_out;
    assign bus.ovf    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_addsub_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_addsub_seq_ctrl
//  Purpose  : Self-checking bench for addsub_seq_ctrl against an arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_addsub_seq_ctrl;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    addsub_seq_ctrl_if #(.NIBBLES(NIB)) bus ();

    addsub_seq_ctrl #(.NIBBLES(NIB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Returns {c_out, ovf, result} from plain W+1-bit arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic o);
        logic [W:0]   full;
        logic [W-1:0] r;
        logic         v;
        if (!o) full = {1'b0, x} + {1'b0, y};
        else    full = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        r = full[W-1:0];
        if (!o) v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        else    v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        return {full[W], v, r};
    endfunction

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic top,
                          input logic [W-1:0] er, input logic ec, input logic ev,
                          input string nm);
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.op = top; bus.a = ta; bus.b = tb_v;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 20) begin
            n_checks++;
            if (bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s busy: got %b expected 1 (cycle %0d)", nm, bus.busy, lat);
            end
            bus.a = W'($urandom); bus.b = W'($urandom); bus.op = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat !== NIB + 1) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", nm, lat, NIB + 1);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_at_done: got %b expected 0", nm, bus.busy);
        end
        n_checks++;
        if ({bus.c_out, bus.ovf, bus.result} !== {ec, ev, er}) begin
            n_fail++;
            $display("FAIL %s result: got r=%h c=%b v=%b expected r=%h c=%b v=%b",
                     nm, bus.result, bus.c_out, bus.ovf, er, ec, ev);
        end
        @(negedge clk);
        n_checks++;
        if ({bus.done, bus.c_out, bus.ovf, bus.result} !== {1'b0, ec, ev, er}) begin
            n_fail++;
            $display("FAIL %s hold: got d=%b r=%h c=%b v=%b expected d=0 r=%h c=%b v=%b",
                     nm, bus.done, bus.result, bus.c_out, bus.ovf, er, ec, ev);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 16'h1111; bus.b = 16'h2222;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.result, bus.c_out, bus.ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b r=%h c=%b v=%b expected all 0",
                     bus.busy, bus.done, bus.result, bus.c_out, bus.ovf);
        end
        bus.start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_directed();
        run_op(16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, "add_basic");
        run_op(16'h0002, 16'h0003, 1'b1, 16'hFFFF, 1'b0, 1'b0, "sub_borrow");
        run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap");
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
    endtask

    task automatic test_random();
        logic [W-1:0] x, y;
        logic         o;
        logic [W+1:0] e;
        for (int i = 0; i < 24; i++) begin
            x = W'($urandom); y = W'($urandom); o = 1'($urandom);
            if (i % 6 == 0) y = x;
            e = model(x, y, o);
            run_op(x, y, o, e[W-1:0], e[W+1], e[W], "random");
        end
    endtask

    task automatic test_start_while_busy();
        int n_done = 0;
        logic [W-1:0] seen = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 16'h1234; bus.b = 16'h0FCD;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b1; bus.a = 16'hAAAA; bus.b = 16'h5555;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done === 1'b1) begin
                n_done++;
                seen = bus.result;
            end
            @(negedge clk);
        end
        n_checks++;
        if (n_done !== 1) begin
            n_fail++;
            $display("FAIL busy_start done_count: got %0d expected 1", n_done);
        end
        n_checks++;
        if (seen !== 16'h2201 || bus.result !== 16'h2201) begin
            n_fail++;
            $display("FAIL busy_start result: got %h/%h expected 2201", seen, bus.result);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start idle: got busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid_op();
        int n_done = 0;
        logic [W+1:0] e;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 16'h7FFF; bus.b = 16'h0001;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.result, bus.c_out, bus.ovf} !== '0) begin
            n_fail++;
            $display("FAIL midreset state: got busy=%b done=%b r=%h c=%b v=%b expected all 0",
                     bus.busy, bus.done, bus.result, bus.c_out, bus.ovf);
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) n_done++;
            @(negedge clk);
        end
        n_checks++;
        if (n_done !== 0) begin
            n_fail++;
            $display("FAIL midreset activity: got %0d busy/done cycles expected 0", n_done);
        end
        e = model(16'h9C3A, 16'h4E21, 1'b1);
        run_op(16'h9C3A, 16'h4E21, 1'b1, e[W-1:0], e[W+1], e[W], "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] va [4];
        logic [W-1:0] vb [4];
        logic         vo [4];
        logic [W+1:0] e;
        int k = 0, cyc = 0, last = 0;
        for (int i = 0; i < 4; i++) begin
            va[i] = W'($urandom); vb[i] = W'($urandom); vo[i] = 1'($urandom);
        end
        @(negedge clk);
        bus.start = 1'b1; bus.a = va[0]; bus.b = vb[0]; bus.op = vo[0];
        while (k < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.done === 1'b1) begin
                e = model(va[k], vb[k], vo[k]);
                n_checks++;
                if ({bus.c_out, bus.ovf, bus.result} !== e) begin
                    n_fail++;
                    $display("FAIL b2b result[%0d]: got r=%h c=%b v=%b expected r=%h c=%b v=%b",
                             k, bus.result, bus.c_out, bus.ovf, e[W-1:0], e[W+1], e[W]);
                end
                if (k > 0) begin
                    n_checks++;
                    if (cyc - last !== NIB + 2) begin
                        n_fail++;
                        $display("FAIL b2b spacing[%0d]: got %0d expected %0d",
                                 k, cyc - last, NIB + 2);
                    end
                end
                last = cyc;
                k++;
                if (k < 4) begin
                    bus.a = va[k]; bus.b = vb[k]; bus.op = vo[k];
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        n_checks++;
        if (k !== 4) begin
            n_fail++;
            $display("FAIL b2b timeout: got %0d ops expected 4", k);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
        reset = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_reset_mid_op();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
